// File: rtl/xsw_tgt_arb.sv
// xsw_tgt_arb: per-target round-robin request arbiter and in-order response steerer.
// One target port is shared by N_INIT initiators. The winner of every accepted request is
// queued in an outstanding-ID FIFO, and each target response goes to the initiator at its head.
// Optional build macro: XSW_ARB_WDOG_EN enables the sticky target-stall watchdog (wdog_err).
module xsw_tgt_arb #(
  parameter int unsigned N_INIT   = 3,
  parameter int unsigned REQ_W    = 66,
  parameter int unsigned RSP_W    = 37,
  parameter int unsigned OSTD     = 4,
  parameter int unsigned WDOG_LIM = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_INIT-1:0]          init_req_vld,
  input  logic [N_INIT*REQ_W-1:0]    init_req_pkt,
  output logic [N_INIT-1:0]          init_req_gnt,
  output logic                       tgt_req_vld,
  output logic [REQ_W-1:0]           tgt_req_pkt,
  input  logic                       tgt_req_gnt,
  input  logic                       tgt_rsp_vld,
  input  logic [RSP_W-1:0]           tgt_rsp_pkt,
  output logic                       tgt_rsp_gnt,
  output logic [N_INIT-1:0]          init_rsp_vld,
  output logic [RSP_W-1:0]           init_rsp_pkt,
  input  logic [N_INIT-1:0]          init_rsp_gnt,
  output logic [$clog2(OSTD+1)-1:0]  ostd_cnt,
  output logic                       wdog_err
);

  localparam int unsigned IDW = $clog2(N_INIT);
  localparam int unsigned PW  = $clog2(OSTD);
  localparam int unsigned CW  = $clog2(OSTD+1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   win_q;
  logic             req_vld_q;

  logic [IDW-1:0]   ids_q [OSTD];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    cnt_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand_idx;
  logic             fifo_empty;
  logic             fifo_full;
  logic [IDW-1:0]   head_id;
  logic             push;
  logic             pop;

  logic [REQ_W-1:0] req_arr [N_INIT];

  for (genvar g = 0; g < N_INIT; g++) begin : g_req_unpack
    assign req_arr[g] = init_req_pkt[g*REQ_W +: REQ_W];
  end

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(OSTD));
  assign head_id    = ids_q[head_q];
  assign push       = (state_q == StBusy) && tgt_req_gnt;
  assign pop        = tgt_rsp_vld && tgt_rsp_gnt;

  // Round-robin pick: first requester strictly after rr_ptr, wrapping modulo N_INIT.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= N_INIT; k++) begin
      cand_idx = IDW'((32'(rr_ptr_q) + 32'(k)) % N_INIT);
      if (!win_found && init_req_vld[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Arbiter FSM; the winner is frozen for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rr_ptr_q  <= IDW'(N_INIT - 1);
      win_q     <= '0;
      req_vld_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (win_found && !fifo_full) begin
            win_q     <= win_idx;
            state_q   <= StBusy;
            req_vld_q <= 1'b1;
          end
        end
        StBusy: begin
          if (tgt_req_gnt) begin
            rr_ptr_q  <= win_q;
            state_q   <= StIdle;
            req_vld_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          req_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign tgt_req_vld = req_vld_q;
  assign tgt_req_pkt = req_arr[win_q];

  // Request grant is passed straight through to the held winner only.
  always_comb begin
    init_req_gnt = '0;
    for (int i = 0; i < N_INIT; i++) begin
      init_req_gnt[i] = (state_q == StBusy) && (win_q == IDW'(i)) && tgt_req_gnt;
    end
  end

  // Outstanding-ID FIFO; pointers wrap naturally since OSTD is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        ids_q[tail_q] <= win_q;
        tail_q        <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign ostd_cnt = cnt_q;

  // Response steering is purely combinational; responses with no outstanding ID stall.
  always_comb begin
    init_rsp_vld = '0;
    for (int i = 0; i < N_INIT; i++) begin
      init_rsp_vld[i] = tgt_rsp_vld && !fifo_empty && (head_id == IDW'(i));
    end
    tgt_rsp_gnt = !fifo_empty && init_rsp_gnt[head_id];
  end

  assign init_rsp_pkt = tgt_rsp_pkt;

`ifdef XSW_ARB_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_LIM+1);

  logic [WW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic          wdog_err_q;

  // Stall counter: counts ungranted BUSY cycles, clears on transfer, saturates at the limit.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (push) begin
      wdog_cnt_d = '0;
    end else if ((state_q == StBusy) && !tgt_req_gnt && (wdog_cnt_q != WW'(WDOG_LIM))) begin
      wdog_cnt_d = wdog_cnt_q + WW'(1);
    end
  end

  // Sticky error flag, set in the same edge the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (wdog_cnt_d == WW'(WDOG_LIM)) begin
        wdog_err_q <= 1'b1;
      end
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_xsw_tgt_arb.sv
// Directed self-checking bench for xsw_tgt_arb (N_INIT=3, OSTD=4, WDOG_LIM=8).
module tb_xsw_tgt_arb;

  localparam int unsigned N_INIT = 3;
  localparam int unsigned REQ_W  = 66;
  localparam int unsigned RSP_W  = 37;
  localparam int unsigned OSTD   = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N_INIT-1:0]         init_req_vld;
  logic [N_INIT*REQ_W-1:0]   init_req_pkt;
  logic [N_INIT-1:0]         init_req_gnt;
  logic                      tgt_req_vld;
  logic [REQ_W-1:0]          tgt_req_pkt;
  logic                      tgt_req_gnt;
  logic                      tgt_rsp_vld;
  logic [RSP_W-1:0]          tgt_rsp_pkt;
  logic                      tgt_rsp_gnt;
  logic [N_INIT-1:0]         init_rsp_vld;
  logic [RSP_W-1:0]          init_rsp_pkt;
  logic [N_INIT-1:0]         init_rsp_gnt;
  logic [2:0]                ostd_cnt;
  logic                      wdog_err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  xsw_tgt_arb #(
    .N_INIT   (N_INIT),
    .REQ_W    (REQ_W),
    .RSP_W    (RSP_W),
    .OSTD     (OSTD),
    .WDOG_LIM (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_req_vld (init_req_vld),
    .init_req_pkt (init_req_pkt),
    .init_req_gnt (init_req_gnt),
    .tgt_req_vld  (tgt_req_vld),
    .tgt_req_pkt  (tgt_req_pkt),
    .tgt_req_gnt  (tgt_req_gnt),
    .tgt_rsp_vld  (tgt_rsp_vld),
    .tgt_rsp_pkt  (tgt_rsp_pkt),
    .tgt_rsp_gnt  (tgt_rsp_gnt),
    .init_rsp_vld (init_rsp_vld),
    .init_rsp_pkt (init_rsp_pkt),
    .init_rsp_gnt (init_rsp_gnt),
    .ostd_cnt     (ostd_cnt),
    .wdog_err     (wdog_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pkt_lo(input int i);
    return {32'hA0A0_0000 | 32'(i), 32'h5500_0000 | 32'(i)};
  endfunction

  task automatic do_reset();
    rst          = 1'b1;
    init_req_vld = '0;
    tgt_req_gnt  = 1'b0;
    tgt_rsp_vld  = 1'b0;
    tgt_rsp_pkt  = '0;
    init_rsp_gnt = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One request from initiator idx with the target granting immediately.
  task automatic accept_one(input int idx);
    init_req_vld = N_INIT'(1 << idx);
    tgt_req_gnt  = 1'b1;
    step();
    check_val("acc_gnt", 64'(init_req_gnt), 64'(1) << idx);
    step();
    init_req_vld = '0;
  endtask

  // One response that must steer to exp_vld with its payload intact.
  task automatic rsp_one(input logic [RSP_W-1:0] pkt, input logic [N_INIT-1:0] exp_vld);
    tgt_rsp_vld  = 1'b1;
    tgt_rsp_pkt  = pkt;
    init_rsp_gnt = '1;
    #1;
    check_val("rsp_vld", 64'(init_rsp_vld), 64'(exp_vld));
    check_val("rsp_pkt", 64'(init_rsp_pkt), 64'(pkt));
    check_val("rsp_gnt", 64'(tgt_rsp_gnt), 64'd1);
    step();
    tgt_rsp_vld = 1'b0;
  endtask

  initial begin
    int n_xfer;
    int order [4];
    order = '{0, 1, 2, 0};
    for (int i = 0; i < N_INIT; i++) begin
      init_req_pkt[i*REQ_W +: REQ_W] = {2'b10, pkt_lo(i)};
    end

    // Reset state
    do_reset();
    check_val("rst_ostd", 64'(ostd_cnt), 64'd0);
    check_val("rst_vld", 64'(tgt_req_vld), 64'd0);
    check_val("rst_gnt", 64'(init_req_gnt), 64'd0);
    check_val("rst_rspv", 64'(init_rsp_vld), 64'd0);
    check_val("rst_rspg", 64'(tgt_rsp_gnt), 64'd0);
    check_val("rst_wdog", 64'(wdog_err), 64'd0);

    // Reset priority: all request, accept order 0,1,2,0 with an idle cycle in between
    init_req_vld = '1;
    tgt_req_gnt  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check_val("rr_vld", 64'(tgt_req_vld), 64'(c % 2));
      if (c % 2 == 1) begin
        check_val("rr_gnt", 64'(init_req_gnt), 64'(1) << order[c/2]);
        check_val("rr_pkt", tgt_req_pkt[63:0], pkt_lo(order[c/2]));
      end
      step();
    end
    check_val("rr_full", 64'(ostd_cnt), 64'd4);

    // Outstanding limit: initiator 1 only, no responses
    do_reset();
    init_req_vld = 3'b010;
    tgt_req_gnt  = 1'b1;
    n_xfer = 0;
    for (int c = 0; c < 14; c++) begin
      if (tgt_req_vld && tgt_req_gnt) n_xfer++;
      step();
    end
    check_val("lim_xfer", 64'(n_xfer), 64'd4);
    check_val("lim_ostd", 64'(ostd_cnt), 64'd4);
    check_val("lim_vld", 64'(tgt_req_vld), 64'd0);

    // Response steering: accepts 2,0,2 then three responses
    do_reset();
    accept_one(2);
    accept_one(0);
    accept_one(2);
    check_val("st_ostd3", 64'(ostd_cnt), 64'd3);
    rsp_one(37'h11, 3'b100);
    rsp_one(37'h22, 3'b001);
    rsp_one(37'h33, 3'b100);
    check_val("st_ostd0", 64'(ostd_cnt), 64'd0);

    // Backpressure on the head initiator holds the response
    accept_one(1);
    tgt_rsp_vld  = 1'b1;
    tgt_rsp_pkt  = 37'h44;
    init_rsp_gnt = 3'b101;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_val("bp_gnt", 64'(tgt_rsp_gnt), 64'd0);
      check_val("bp_vld", 64'(init_rsp_vld), 64'b010);
      check_val("bp_ostd", 64'(ostd_cnt), 64'd1);
      step();
    end

    // Request accept and response pop on the same edge
    init_req_vld = 3'b001;
    tgt_req_gnt  = 1'b1;
    step();
    check_val("pp_rgnt", 64'(init_req_gnt), 64'b001);
    init_rsp_gnt = 3'b010;
    #1;
    check_val("pp_sgnt", 64'(tgt_rsp_gnt), 64'd1);
    step();
    tgt_rsp_vld  = 1'b0;
    init_req_vld = '0;
    check_val("pp_ostd", 64'(ostd_cnt), 64'd1);
    rsp_one(37'h55, 3'b001);
    check_val("pp_ostd0", 64'(ostd_cnt), 64'd0);

    // Spurious response with nothing outstanding
    tgt_rsp_vld  = 1'b1;
    tgt_rsp_pkt  = 37'h66;
    init_rsp_gnt = '1;
    for (int c = 0; c < 10; c++) begin
      #1;
      check_val("sp_gnt", 64'(tgt_rsp_gnt), 64'd0);
      check_val("sp_vld", 64'(init_rsp_vld), 64'd0);
      step();
    end
    tgt_rsp_vld = 1'b0;

    // Reset mid-transaction drops outstanding IDs
    accept_one(0);
    accept_one(1);
    do_reset();
    tgt_rsp_vld  = 1'b1;
    init_rsp_gnt = '1;
    #1;
    check_val("mr_ostd", 64'(ostd_cnt), 64'd0);
    check_val("mr_gnt", 64'(tgt_rsp_gnt), 64'd0);
    tgt_rsp_vld = 1'b0;

`ifdef XSW_ARB_WDOG_EN
    // Watchdog: 8 stall cycles in BUSY set the sticky error
    do_reset();
    init_req_vld = 3'b001;
    tgt_req_gnt  = 1'b0;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      check_val("wd_err", 64'(wdog_err), (k == 8) ? 64'd1 : 64'd0);
    end
    tgt_req_gnt = 1'b1;
    step();
    init_req_vld = '0;
    step();
    check_val("wd_stick", 64'(wdog_err), 64'd1);
    do_reset();
    check_val("wd_clr", 64'(wdog_err), 64'd0);
`else
    check_val("wd_tied", 64'(wdog_err), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
